mac_sequencer: RTL and testbench

//   FSM controller for one neuron MAC datapath: Register instances for x, w, acc and out around a pipelined multiplier.
//   On start, walks N_INPUTS operand pairs: read address, load x/w registers, wait out multiplier latency, load accumulator.

---
 rtl/mac_sequencer.sv | 136 +++++++++++++
 tb/tb_mac_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: FSM controller for one neuron MAC datapath.
// Steps through N_INPUTS operand pairs. For each pair it issues a memory read,
// loads the x/w registers, waits out the multiplier pipeline and then loads
// the accumulator. After the last pair it loads the output register and
// pulses done for one cycle.
// All outputs are Moore outputs. They are registered from the next-state
// decode, so every output matches the current state register and no input
// reaches an output combinationally.
// Optional feature: define SEQ_ABORT_EN to add the abort input. While a run is
// in progress, abort returns the FSM to IDLE and suppresses ld_out and done.
module mac_sequencer #(
  parameter int N_INPUTS     = 8,
  parameter int MULT_LATENCY = 3,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  mem_rd,
  output logic                  ld_x,
  output logic                  ld_w,
  output logic                  clr_acc,
  output logic                  ld_acc,
  output logic                  ld_out
);

  // Wait counter width is $clog2(MULT_LATENCY+1), kept at least 1 bit so a
  // combinational multiplier (latency 0) still elaborates cleanly.
  localparam int WCNT_W = (MULT_LATENCY > 0) ? $clog2(MULT_LATENCY + 1) : 1;
  localparam logic [WCNT_W-1:0]     WCNT_LAST =
    WCNT_W'((MULT_LATENCY > 0) ? MULT_LATENCY - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_WAIT, S_ACC, S_OUT, S_DONE
  } state_e;

  // Strobe vector bit order: {clr_acc, mem_rd, ld_x, ld_w, ld_acc, ld_out, done}
  typedef logic [6:0] strb_t;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  strb_t                   strb_q, strb_d;
  logic                    busy_q, busy_d;

  // Output decode for a given state. At most one strobe group is active.
  function automatic strb_t decode(input state_e s);
    case (s)
      S_CLEAR: decode = 7'b1000000;
      S_FETCH: decode = 7'b0100000;
      S_LOAD:  decode = 7'b0011000;
      S_ACC:   decode = 7'b0000100;
      S_OUT:   decode = 7'b0000010;
      S_DONE:  decode = 7'b0000001;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // Next-state, counter and output computation.
  always_comb begin
    // NOTE: every variable gets a default value first. Without it, a path
    // that leaves a variable unassigned infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        wcnt_d  = '0;
        state_d = (MULT_LATENCY == 0) ? S_ACC : S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WCNT_LAST) state_d = S_ACC;
      end
      S_ACC: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_OUT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_OUT:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SEQ_ABORT_EN
    // Abort cancels a run in progress. In IDLE it is ignored, so start wins.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      wcnt_d  = '0;
    end
`endif
    strb_d = decode(state_d);
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples values from before the edge.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      strb_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
    end
  end

  assign {clr_acc, mem_rd, ld_x, ld_w, ld_acc, ld_out, done} = strb_q;
  assign busy     = busy_q;
  // The index register is held from FETCH through ACC, so it drives the address directly.
  assign addr_out = idx_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer. A scoreboard is filled by the stimulus with the
// expected strobe events. A monitor per DUT pops an entry and compares it
// whenever that DUT shows a strobe. dut0 (N=8, L=3) also drives a small
// datapath model; dut1 uses N=1, L=0.
module tb_mac_sequencer;

  typedef struct {
    int         cyc;
    logic [6:0] strb;
    logic [2:0] addr;
    bit         chk_addr;
  } ev_t;

  localparam logic [6:0] E_CLR  = 7'b1000000;
  localparam logic [6:0] E_RD   = 7'b0100000;
  localparam logic [6:0] E_LD   = 7'b0011000;
  localparam logic [6:0] E_ACC  = 7'b0000100;
  localparam logic [6:0] E_OUT  = 7'b0000010;
  localparam logic [6:0] E_DONE = 7'b0000001;
  localparam int EXP_OUT = 72;  // sum of (1..8) * 2

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
`ifdef SEQ_ABORT_EN
  logic abort0 = 1'b0, abort1 = 1'b0;
`endif
  logic       busy0, done0, rd0, ldx0, ldw0, clr0, ldacc0, ldout0;
  logic [2:0] addr0;
  logic       busy1, done1, rd1, ldx1, ldw1, clr1, ldacc1, ldout1;
  logic [2:0] addr1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_sequencer #(.N_INPUTS(8), .MULT_LATENCY(3), .ADDR_WIDTH(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
`ifdef SEQ_ABORT_EN
    .abort(abort0),
`endif
    .busy(busy0), .done(done0), .addr_out(addr0), .mem_rd(rd0),
    .ld_x(ldx0), .ld_w(ldw0), .clr_acc(clr0), .ld_acc(ldacc0), .ld_out(ldout0)
  );

  mac_sequencer #(.N_INPUTS(1), .MULT_LATENCY(0), .ADDR_WIDTH(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef SEQ_ABORT_EN
    .abort(abort1),
`endif
    .busy(busy1), .done(done1), .addr_out(addr1), .mem_rd(rd1),
    .ld_x(ldx1), .ld_w(ldw1), .clr_acc(clr1), .ld_acc(ldacc1), .ld_out(ldout1)
  );

  // Datapath model around dut0: x = 1..8, w = 2, 3-stage multiplier.
  int xmem[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int wmem[8] = '{2, 2, 2, 2, 2, 2, 2, 2};
  int rx, rw, xr, wr, p1, p2, p3, acc, outr;
  always @(posedge clk) begin
    if (rd0) begin
      rx <= xmem[addr0];
      rw <= wmem[addr0];
    end
    if (ldx0) xr <= rx;
    if (ldw0) wr <= rw;
    p1 <= xr * wr;
    p2 <= p1;
    p3 <= p2;
    if (clr0) acc <= 0;
    else if (ldacc0) acc <= acc + p3;
    if (ldout0) outr <= acc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected strobe events for one run started (start high) in cycle c0.
  task automatic push_run(input int which, input int c0, input int n, input int l);
    ev_t e;
    e = '{c0 + 1, E_CLR, 3'd0, 1'b0};
    if (which == 0) q0.push_back(e); else q1.push_back(e);
    for (int i = 0; i < n; i++) begin
      int b = c0 + 2 + i * (3 + l);
      e = '{b, E_RD, 3'(i), 1'b1};
      if (which == 0) q0.push_back(e); else q1.push_back(e);
      e = '{b + 1, E_LD, 3'(i), 1'b1};
      if (which == 0) q0.push_back(e); else q1.push_back(e);
      e = '{b + 2 + l, E_ACC, 3'(i), 1'b1};
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
    e = '{c0 + 2 + n * (3 + l), E_OUT, 3'd0, 1'b0};
    if (which == 0) q0.push_back(e); else q1.push_back(e);
    e = '{c0 + 3 + n * (3 + l), E_DONE, 3'd0, 1'b0};
    if (which == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Drop expected events that a reset or abort cancels (after cycle lim).
  task automatic flush(input int which, input int lim);
    if (which == 0) begin
      while (q0.size() > 0 && q0[$].cyc > lim) void'(q0.pop_back());
    end else begin
      while (q1.size() > 0 && q1[$].cyc > lim) void'(q1.pop_back());
    end
  endtask

  task automatic score(input int which, input logic [6:0] strb, input logic [2:0] addr,
                       input logic busy);
    ev_t e;
    if (strb !== 7'd0) begin
      if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
        check($sformatf("dut%0d unexpected strobe", which), {25'd0, strb}, 32'd0);
      end else begin
        if (which == 0) e = q0.pop_front(); else e = q1.pop_front();
        check($sformatf("dut%0d event cycle", which), e.cyc, cyc);
        check($sformatf("dut%0d strobes", which), {25'd0, strb}, {25'd0, e.strb});
        if (e.chk_addr)
          check($sformatf("dut%0d addr_out", which), {29'd0, addr}, {29'd0, e.addr});
        if (strb[0]) begin
          check($sformatf("dut%0d busy at done", which), {31'd0, busy}, 32'd1);
          if (which == 0) check("output register", outr, EXP_OUT);
        end
      end
    end
  endtask

  // Monitors: sample 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    score(0, {clr0, rd0, ldx0, ldw0, ldacc0, ldout0, done0}, addr0, busy0);
    score(1, {clr1, rd1, ldx1, ldw1, ldacc1, ldout1, done1}, addr1, busy1);
  end

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy0", {31'd0, busy0}, 32'd0);
    check("reset strobes0", {25'd0, clr0, rd0, ldx0, ldw0, ldacc0, ldout0, done0}, 32'd0);
    check("reset busy1", {31'd0, busy1}, 32'd0);
    rst = 1'b0;

    // Test 1: single start pulse, N=8, L=3.
    @(negedge clk); c0 = cyc; start0 = 1'b1;
    push_run(0, c0, 8, 3);
    @(negedge clk); start0 = 1'b0;
    check("busy after start", {31'd0, busy0}, 32'd1);
    repeat (60) @(negedge clk);
    check("idle after run", {31'd0, busy0}, 32'd0);

    // Test 2: start held for 60 cycles gives exactly two runs.
    @(negedge clk); c0 = cyc; start0 = 1'b1;
    push_run(0, c0, 8, 3);
    push_run(0, c0 + 52, 8, 3);
    repeat (60) @(negedge clk); start0 = 1'b0;
    repeat (60) @(negedge clk);

    // Test 3: N=1, L=0 single pass without WAIT.
    @(negedge clk); c0 = cyc; start1 = 1'b1;
    push_run(1, c0, 1, 0);
    @(negedge clk); start1 = 1'b0;
    repeat (10) @(negedge clk);

    // Test 4: reset in cycle 20 of a run, then a fresh run.
    @(negedge clk); c0 = cyc; start0 = 1'b1;
    push_run(0, c0, 8, 3);
    @(negedge clk); start0 = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    flush(0, c0 + 20);
    @(posedge clk); #1;
    check("busy after mid-run reset", {31'd0, busy0}, 32'd0);
    check("strobes after mid-run reset",
          {25'd0, clr0, rd0, ldx0, ldw0, ldacc0, ldout0, done0}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); c0 = cyc; start0 = 1'b1;
    push_run(0, c0, 8, 3);
    @(negedge clk); start0 = 1'b0;
    repeat (60) @(negedge clk);

`ifdef SEQ_ABORT_EN
    // Test 6: abort in cycle 10, then abort and start together in IDLE.
    @(negedge clk); c0 = cyc; start0 = 1'b1;
    push_run(0, c0, 8, 3);
    @(negedge clk); start0 = 1'b0;
    repeat (9) @(negedge clk);
    abort0 = 1'b1;
    flush(0, c0 + 10);
    @(posedge clk); #1;
    check("busy after abort", {31'd0, busy0}, 32'd0);
    @(negedge clk); abort0 = 1'b0;
    @(negedge clk); c0 = cyc; start0 = 1'b1; abort0 = 1'b1;
    push_run(0, c0, 8, 3);
    @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
    repeat (60) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("dut0 scoreboard drained", q0.size(), 32'd0);
    check("dut1 scoreboard drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
